vga_display_sched: RTL
======================

VGA_DISPLAY_SCHED -- requirements
Module: vga_display_sched

Interface
REQ-001 Parameter H_DISP, default 11'd640, active pixels per line.
REQ-002 Parameters H_FP / H_SYNC / H_BP, defaults 11'd16 / 11'd96 / 11'd48, horizontal porch and sync widths in clocks.
REQ-003 Parameter V_DISP, default 11'd480, active lines per frame.
REQ-004 Parameters V_FP / V_SYNC / V_BP, defaults 11'd10 / 11'd2 / 11'd33, vertical porch and sync widths in lines.
REQ-005 Parameter DEB_CNT, default 20'd500_000, clocks of stable key level required to accept a change.
REQ-006 Parameter AUTO_FRAMES, default 8'd120, frames per mode in auto-cycle.
REQ-007 Parameter MODE_NUM, default 3'd4, number of display modes (1..4).
REQ-008 VGA_CLK  in  1  pixel clock; the block's only clock.
REQ-009 RST_N  in  1  reset; asynchronous, active-low.
REQ-010 KEY_N  in  1  raw mode-advance push button, asynchronous, low = pressed.
REQ-011 AUTO_EN  in  1  high = advance mode automatically every AUTO_FRAMES frames.
REQ-012 VGA_HS / VGA_VS  out  1 each  sync, active-low.
REQ-013 VGA_IF_RGBEN  out  4  one-hot display enable; bit MODE high during active video only.
REQ-014 CURRENT_X / CURRENT_Y  out  11 each  pixel position aligned with VGA_IF_RGBEN.
REQ-015 DISPLAY_X / DISPLAY_Y  out  11 each  constant H_DISP / V_DISP.
REQ-016 MODE  out  2  current display mode.
REQ-017 FRAME_START  out  1  one-clock pulse aligned with pixel (0,0).

Function
REQ-018 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP), wrapping to 0; v_cnt SHALL increment on h_cnt wrap and wrap to 0 after V_TOTAL-1.
REQ-019 Active SHALL be h_cnt < H_DISP and v_cnt < V_DISP.
REQ-020 HS low SHALL be H_DISP+H_FP <= h_cnt < H_DISP+H_FP+H_SYNC; VS low SHALL be V_DISP+V_FP <= v_cnt < V_DISP+V_FP+V_SYNC (whole lines).
REQ-021 All outputs except DISPLAY_X/Y SHALL be registered decodes of the counters, i.e. exactly one clock behind h_cnt/v_cnt, mutually aligned.
REQ-022 CURRENT_X/Y SHALL equal the delayed h_cnt/v_cnt at all times, including blanking.
REQ-023 VGA_IF_RGBEN SHALL be 4'b0 during blanking; during active video only bit MODE is set; bits >= MODE_NUM never assert.
REQ-024 KEY_N SHALL pass a 2-flop synchronizer; a debounce counter resets whenever the synchronized level equals the accepted level, else increments; at DEB_CNT-1 the accepted level takes the synchronized value and the counter clears.
REQ-025 An accepted 1->0 transition SHALL produce one press event and set a pending flag; release produces no event; further presses while pending are absorbed.
REQ-026 Frame end SHALL be h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1; MODE changes only at frame end, so no frame shows two modes.
REQ-027 At frame end with pending set, MODE SHALL advance (MODE_NUM-1 wraps to 0), pending clears and the auto frame counter clears.
REQ-028 With AUTO_EN high, the frame counter SHALL increment at each frame end; at AUTO_FRAMES-1 it advances MODE once and clears; with AUTO_EN low it holds 0.
REQ-029 Pending and auto expiry at the same frame end SHALL advance MODE by exactly one.
REQ-030 A press event in the same clock as frame end SHALL remain pending to the next frame end.

Reset
REQ-031 While RST_N low: counters 0, MODE 0, pending 0, frame counter 0, debounce counter 0, sync flops and accepted level 1, HS 1, VS 1, VGA_IF_RGBEN 0, CURRENT_X/Y 0, FRAME_START 0.
REQ-032 First clock after RST_N rises SHALL output pixel (0,0): FRAME_START 1, VGA_IF_RGBEN 4'b0001; reset mid-frame restarts timing at (0,0) and abandons pending presses.

Verification (H_DISP=8,H_FP=1,H_SYNC=2,H_BP=1,V_DISP=4,V_FP=1,V_SYNC=1,V_BP=1,DEB_CNT=4,AUTO_FRAMES=2,MODE_NUM=3)
REQ-033 Free run, AUTO_EN 0 -> line 12 clocks, frame 84 clocks; HS low at X=9,10; VS low on Y=5; RGBEN 4'b0001 for X<8,Y<4 only; FRAME_START every 84 clocks.
REQ-034 KEY_N low 10 clocks mid-frame -> MODE 0->1 exactly at next frame end, next frame RGBEN 4'b0010; glitch of 2 clocks -> no change.
REQ-035 Three separate presses -> MODE 1,2,0 (wrap at MODE_NUM); RGBEN bit 3 never set.
REQ-036 AUTO_EN 1 -> MODE advances every 2 frames; press accepted in the frame of auto expiry -> single advance.
REQ-037 Assert RST_N low mid-line with pending set -> all outputs at REQ-031 values immediately; after release MODE 0, FRAME_START next clock.

Source files
------------

// File: rtl/vga_display_sched.sv
// vga_display_sched
//   VGA raster timing generator with a debounced mode-advance key and an
//   optional auto-cycle. Mode changes are applied only at the end of a
//   frame, so every frame is drawn entirely in one mode.
//
// Ports
//   VGA_CLK        in   pixel clock, the only clock
//   RST_N          in   asynchronous active-low reset
//   KEY_N          in   raw mode-advance push button, low = pressed
//   AUTO_EN        in   advance mode every AUTO_FRAMES frames
//   VGA_HS/VGA_VS  out  active-low syncs
//   VGA_IF_RGBEN   out  one-hot display enable, bit MODE during active video
//   CURRENT_X/Y    out  pixel position aligned with VGA_IF_RGBEN
//   DISPLAY_X/Y    out  constant active width / height
//   MODE           out  current display mode
//   FRAME_START    out  one-clock pulse with pixel (0,0)
module vga_display_sched #(
  parameter logic [10:0] H_DISP      = 11'd640,
  parameter logic [10:0] H_FP        = 11'd16,
  parameter logic [10:0] H_SYNC      = 11'd96,
  parameter logic [10:0] H_BP        = 11'd48,
  parameter logic [10:0] V_DISP      = 11'd480,
  parameter logic [10:0] V_FP        = 11'd10,
  parameter logic [10:0] V_SYNC      = 11'd2,
  parameter logic [10:0] V_BP        = 11'd33,
  parameter logic [19:0] DEB_CNT     = 20'd500_000,
  parameter logic [7:0]  AUTO_FRAMES = 8'd120,
  parameter logic [2:0]  MODE_NUM    = 3'd4
) (
  input  logic        VGA_CLK,
  input  logic        RST_N,
  input  logic        KEY_N,
  input  logic        AUTO_EN,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [3:0]  VGA_IF_RGBEN,
  output logic [10:0] CURRENT_X,
  output logic [10:0] CURRENT_Y,
  output logic [10:0] DISPLAY_X,
  output logic [10:0] DISPLAY_Y,
  output logic [1:0]  MODE,
  output logic        FRAME_START
);

  localparam logic [10:0] H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
  localparam logic [10:0] V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] HS_START = H_DISP + H_FP;
  localparam logic [10:0] HS_END   = H_DISP + H_FP + H_SYNC;
  localparam logic [10:0] VS_START = V_DISP + V_FP;
  localparam logic [10:0] VS_END   = V_DISP + V_FP + V_SYNC;

  logic [10:0] r_h_cnt, r_v_cnt;
  logic        r_key_s1, r_key_s2, r_key_acc;
  logic [19:0] r_deb_cnt;
  logic        r_pending;
  logic [7:0]  r_frame_cnt;
  logic [1:0]  r_mode;
  logic        r_hs, r_vs, r_fs;
  logic [3:0]  r_rgben;
  logic [10:0] r_x, r_y;
  logic [1:0]  r_mode_out;

  logic        w_h_last, w_v_last, w_frame_end;
  logic        w_active, w_hs_n, w_vs_n, w_fs;
  logic [3:0]  w_rgben;
  logic        w_deb_hit, w_press, w_auto_hit, w_advance;
  logic [1:0]  w_mode_nxt;

  assign w_h_last    = (r_h_cnt == H_TOTAL - 11'd1);
  assign w_v_last    = (r_v_cnt == V_TOTAL - 11'd1);
  assign w_frame_end = w_h_last && w_v_last;

  // ---- raster counters ----
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_h_cnt <= 11'd0;
      r_v_cnt <= 11'd0;
    end else if (w_h_last) begin
      r_h_cnt <= 11'd0;
      r_v_cnt <= w_v_last ? 11'd0 : r_v_cnt + 11'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 11'd1;
    end
  end

  // ---- key synchronizer and debounce ----
  // The counter only runs while the synchronized level disagrees with the
  // accepted level, so any bounce back restarts the stability window.
  assign w_deb_hit = (r_key_s2 != r_key_acc) && (r_deb_cnt == DEB_CNT - 20'd1);
  assign w_press   = w_deb_hit && !r_key_s2;

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_key_s1  <= 1'b1;
      r_key_s2  <= 1'b1;
      r_key_acc <= 1'b1;
      r_deb_cnt <= 20'd0;
    end else begin
      r_key_s1 <= KEY_N;
      r_key_s2 <= r_key_s1;
      if (r_key_s2 == r_key_acc) begin
        r_deb_cnt <= 20'd0;
      end else if (w_deb_hit) begin
        r_key_acc <= r_key_s2;
        r_deb_cnt <= 20'd0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 20'd1;
      end
    end
  end

  // ---- mode scheduling ----
  // A pending press and an auto expiry at the same frame end collapse into
  // a single advance. A press landing on the frame-end clock itself is kept
  // pending for the following frame end.
  assign w_auto_hit = AUTO_EN && (r_frame_cnt == AUTO_FRAMES - 8'd1);
  assign w_advance  = w_frame_end && (r_pending || w_auto_hit);
  assign w_mode_nxt = ({1'b0, r_mode} == MODE_NUM - 3'd1) ? 2'd0 : r_mode + 2'd1;

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pending   <= 1'b0;
      r_frame_cnt <= 8'd0;
      r_mode      <= 2'd0;
    end else begin
      r_pending <= w_frame_end ? w_press : (r_pending | w_press);
      if (w_advance) r_mode <= w_mode_nxt;
      if (!AUTO_EN) begin
        r_frame_cnt <= 8'd0;
      end else if (w_frame_end) begin
        r_frame_cnt <= w_advance ? 8'd0 : r_frame_cnt + 8'd1;
      end
    end
  end

  // ---- output decode register ----
  // Every registered output is decoded from the same counter values, so
  // they all lag the counters by exactly one clock and stay aligned.
  assign w_active = (r_h_cnt < H_DISP) && (r_v_cnt < V_DISP);
  assign w_hs_n   = !((r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
  assign w_vs_n   = !((r_v_cnt >= VS_START) && (r_v_cnt < VS_END));
  assign w_rgben  = w_active ? (4'b0001 << r_mode) : 4'b0000;
  assign w_fs     = (r_h_cnt == 11'd0) && (r_v_cnt == 11'd0);

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_hs       <= 1'b1;
      r_vs       <= 1'b1;
      r_rgben    <= 4'b0000;
      r_x        <= 11'd0;
      r_y        <= 11'd0;
      r_mode_out <= 2'd0;
      r_fs       <= 1'b0;
    end else begin
      r_hs       <= w_hs_n;
      r_vs       <= w_vs_n;
      r_rgben    <= w_rgben;
      r_x        <= r_h_cnt;
      r_y        <= r_v_cnt;
      r_mode_out <= r_mode;
      r_fs       <= w_fs;
    end
  end

  assign VGA_HS       = r_hs;
  assign VGA_VS       = r_vs;
  assign VGA_IF_RGBEN = r_rgben;
  assign CURRENT_X    = r_x;
  assign CURRENT_Y    = r_y;
  assign MODE         = r_mode_out;
  assign FRAME_START  = r_fs;
  assign DISPLAY_X    = H_DISP;
  assign DISPLAY_Y    = V_DISP;

endmodule
